l1_dcache: RTL and testbench

//  Direct-mapped, write-back, write-allocate L1 data cache for the pipelined LC-3b core.

---
 rtl/l1_dcache_pkg.sv | 9 +
 rtl/l1_dcache_if.sv | 47 ++++
 rtl/l1_dcache_array.sv | 62 ++++++
 rtl/l1_dcache.sv | 129 ++++++++++++
 tb/tb_l1_dcache.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/l1_dcache_pkg.sv
// l1_dcache_pkg: shared types for the L1 data cache.
//   lc3b_c_block         128-bit cache line
//   LC3B_C_OFFSET_W      byte-offset width within a line
//   lc3b_dcache_state_t  control FSM states
package l1_dcache_pkg;
  typedef logic [127:0] lc3b_c_block;
  localparam int LC3B_C_OFFSET_W = 4;
  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} lc3b_dcache_state_t;
endpackage

// File: rtl/l1_dcache_if.sv
// l1_dcache_if: CPU-side and physical-memory-side bus of the L1 data cache.
//   CPU:  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable -> cache
//         mem_rdata, mem_resp <- cache
//   PMEM: pmem_read, pmem_write, pmem_address, pmem_wdata <- cache
//         pmem_rdata, pmem_resp -> cache
//   With DCACHE_PERF_EN defined, hit_count/miss_count are also carried.
//   Modports: slave = the cache, master = the core/memory environment.
interface l1_dcache_if;
  import l1_dcache_pkg::*;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  lc3b_c_block pmem_wdata;
  lc3b_c_block pmem_rdata;
  logic        pmem_resp;
`ifdef DCACHE_PERF_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata,
           hit_count, miss_count
  );
  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata,
           hit_count, miss_count
  );
`else
  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
`endif
endinterface

// File: rtl/l1_dcache_array.sv
// l1_dcache_array: NUM_SETS x {valid, dirty, tag, line} storage.
//   clk, rst_n     clock; async active-low clear of valid/dirty only
//   i_idx          set index for both read and write
//   o_valid/o_dirty/o_tag/o_line  asynchronous read of the indexed set
//   i_byte_we      per-byte write enables into the indexed line
//   i_wdata        line write data (bytes selected by i_byte_we)
//   i_fill         install: write tag, valid=1, dirty=0
//   i_tag          tag written on i_fill
//   i_dirty_set    mark indexed line dirty (store hit)
module l1_dcache_array
  import l1_dcache_pkg::*;
#(
  parameter  int NUM_SETS = 8,
  localparam int IW       = $clog2(NUM_SETS),
  localparam int TAG_W    = 16 - LC3B_C_OFFSET_W - IW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IW-1:0]    i_idx,
  output logic             o_valid,
  output logic             o_dirty,
  output logic [TAG_W-1:0] o_tag,
  output lc3b_c_block      o_line,
  input  logic [15:0]      i_byte_we,
  input  lc3b_c_block      i_wdata,
  input  logic             i_fill,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_dirty_set
);
  logic [NUM_SETS-1:0] r_valid;
  logic [NUM_SETS-1:0] r_dirty;
  logic [TAG_W-1:0]    r_tag  [NUM_SETS];
  logic [7:0]          r_data [NUM_SETS][16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_dirty_set) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

  // Tag and data are deliberately not reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (i_fill) r_tag[i_idx] <= i_tag;
    for (int b = 0; b < 16; b++) begin
      if (i_byte_we[b]) r_data[i_idx][b] <= i_wdata[b*8 +: 8];
    end
  end

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];

  for (genvar gi = 0; gi < 16; gi++) begin : g_rd
    assign o_line[gi*8 +: 8] = r_data[i_idx][gi];
  end
endmodule

// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped, write-back, write-allocate L1 data cache.
//   clk, rst_n  clock; asynchronous active-low reset
//   bus         l1_dcache_if.slave (CPU request/response, pmem line traffic)
//   NUM_SETS    number of lines (power of two, 2..128)
//   Optional: DCACHE_PERF_EN adds saturating hit_count/miss_count.
module l1_dcache
  import l1_dcache_pkg::*;
#(
  parameter  int NUM_SETS = 8,
  localparam int IW       = $clog2(NUM_SETS),
  localparam int TAG_W    = 16 - LC3B_C_OFFSET_W - IW
) (
  input logic        clk,
  input logic        rst_n,
  l1_dcache_if.slave bus
);
  lc3b_dcache_state_t r_state, w_state_next;
  logic [IW-1:0]    r_idx;
  logic [TAG_W-1:0] r_tag;

  logic [IW-1:0]    w_idx_req, w_idx;
  logic [TAG_W-1:0] w_tag_req, w_arr_tag;
  logic [2:0]       w_word;
  logic             w_valid, w_dirty, w_req, w_hit, w_miss;
  lc3b_c_block      w_line, w_arr_wdata;
  logic [15:0]      w_byte_we;
  logic             w_fill, w_dirty_set;
  logic             w_mem_resp, w_pmem_read, w_pmem_write;
  logic [15:0]      w_pmem_address;
  logic             w_unused_a0;

  assign w_word      = bus.mem_address[3:1];
  assign w_idx_req   = bus.mem_address[LC3B_C_OFFSET_W +: IW];
  assign w_tag_req   = bus.mem_address[15 -: TAG_W];
  assign w_unused_a0 = bus.mem_address[0];
  // During a miss the latched index is used so a wandering address can't redirect it.
  assign w_idx  = (r_state == IDLE) ? w_idx_req : r_idx;
  assign w_req  = bus.mem_read | bus.mem_write;
  assign w_hit  = w_valid && (w_arr_tag == w_tag_req);
  assign w_miss = w_req && !w_hit;

  l1_dcache_array #(.NUM_SETS(NUM_SETS)) u_array (
    .clk(clk), .rst_n(rst_n), .i_idx(w_idx),
    .o_valid(w_valid), .o_dirty(w_dirty), .o_tag(w_arr_tag), .o_line(w_line),
    .i_byte_we(w_byte_we), .i_wdata(w_arr_wdata), .i_fill(w_fill),
    .i_tag(r_tag), .i_dirty_set(w_dirty_set)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_tag   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_miss) begin
        r_idx <= w_idx_req;
        r_tag <= w_tag_req;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_mem_resp     = 1'b0;
    w_pmem_read    = 1'b0;
    w_pmem_write   = 1'b0;
    w_pmem_address = '0;
    w_byte_we      = '0;
    w_arr_wdata    = {8{bus.mem_wdata}};
    w_fill         = 1'b0;
    w_dirty_set    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            w_mem_resp = 1'b1;
            // mem_write wins when both read and write are asserted.
            if (bus.mem_write) begin
              w_byte_we[{w_word, 1'b0} +: 2] = bus.mem_byte_enable;
              w_dirty_set = |bus.mem_byte_enable;
            end
          end else begin
            w_state_next = (w_valid && w_dirty) ? WRITEBACK : FILL;
          end
        end
      end
      WRITEBACK: begin
        w_pmem_write   = 1'b1;
        w_pmem_address = {w_arr_tag, r_idx, 4'b0000};
        if (bus.pmem_resp) w_state_next = FILL;
      end
      FILL: begin
        w_pmem_read    = 1'b1;
        w_pmem_address = {r_tag, r_idx, 4'b0000};
        if (bus.pmem_resp) begin
          w_fill       = 1'b1;
          w_byte_we    = '1;
          w_arr_wdata  = bus.pmem_rdata;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign bus.mem_rdata    = w_line[{w_word, 4'b0000} +: 16];
  assign bus.mem_resp     = w_mem_resp;
  assign bus.pmem_read    = w_pmem_read;
  assign bus.pmem_write   = w_pmem_write;
  assign bus.pmem_address = w_pmem_address;
  assign bus.pmem_wdata   = w_line;

`ifdef DCACHE_PERF_EN
  logic [15:0] r_hit_count, r_miss_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_mem_resp && r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
      if (r_state == IDLE && w_miss && r_miss_count != 16'hFFFF)
        r_miss_count <= r_miss_count + 16'd1;
    end
  end
  assign bus.hit_count  = r_hit_count;
  assign bus.miss_count = r_miss_count;
`endif
endmodule

// File: tb/tb_l1_dcache.sv
module tb_l1_dcache;
  localparam int LAT = 2;

  typedef struct {
    logic        chk;
    logic [15:0] d;
  } resp_t;
  typedef struct {
    logic          wr;
    logic [15:0]   a;
    logic [127:0]  d;
  } pm_t;

  logic clk;
  logic rst_n;
  l1_dcache_if bus();

  l1_dcache #(.NUM_SETS(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  resp_t resp_q[$];
  pm_t   pm_q[$];
  logic [127:0] mem [4096];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pm_push(input logic wr, input logic [15:0] a, input logic [127:0] d);
    pm_t p;
    p.wr = wr; p.a = a; p.d = d;
    pm_q.push_back(p);
  endtask

  // Issues one CPU request, holds it until mem_resp, checks the response latency.
  task automatic cpu_req(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] wd, input logic [1:0] be,
                         input logic chk_d, input logic [15:0] exp_d, input int exp_lat);
    resp_t r;
    int lat;
    logic got;
    r.chk = chk_d; r.d = exp_d;
    resp_q.push_back(r);
    bus.mem_read = rd; bus.mem_write = wr; bus.mem_address = a;
    bus.mem_wdata = wd; bus.mem_byte_enable = be;
    lat = 0; got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (bus.mem_resp) got = 1'b1;
      else lat++;
    end
    $display("REQ rd=%0b wr=%0b addr=%04h wdata=%04h be=%02b latency=%0d", rd, wr, a, wd, be, lat);
    if (!got) begin
      checks++; failures++;
      $display("FAIL resp_timeout addr=%04h actual=none required=mem_resp", a);
      void'(resp_q.pop_back());
    end else begin
      chk("latency", 128'(lat), 128'(exp_lat));
    end
    @(posedge clk); #1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
  endtask

  // Response monitor: every mem_resp is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.mem_resp) begin
      checks++;
      if (resp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_resp addr=%04h actual=resp required=none", bus.mem_address);
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        checks--;
        if (r.chk) chk("rdata", 128'(bus.mem_rdata), 128'(r.d));
      end
    end
  end

  // Physical memory model; checks each new pmem transaction against the scoreboard.
  initial begin
    int cnt;
    pm_t p;
    cnt = 0;
    bus.pmem_resp = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0;
        bus.pmem_resp = 1'b0;
      end else if (bus.pmem_resp) begin
        bus.pmem_resp = 1'b0;
      end else if (bus.pmem_read || bus.pmem_write) begin
        if (cnt == 0) begin
          $display("PMEM wr=%0b addr=%04h", bus.pmem_write, bus.pmem_address);
          if (pm_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_pmem addr=%04h actual=wr%0b required=none",
                     bus.pmem_address, bus.pmem_write);
          end else begin
            p = pm_q.pop_front();
            chk("pmem_op", 128'(bus.pmem_write), 128'(p.wr));
            chk("pmem_addr", 128'(bus.pmem_address), 128'(p.a));
            if (p.wr) chk("pmem_wdata", bus.pmem_wdata, p.d);
          end
        end
        cnt++;
        if (cnt == LAT) begin
          cnt = 0;
          bus.pmem_resp = 1'b1;
          if (bus.pmem_write) mem[bus.pmem_address[15:4]] = bus.pmem_wdata;
          else bus.pmem_rdata = mem[bus.pmem_address[15:4]];
        end
      end
    end
  end

  initial begin
    logic got;
    // Every word initially holds its own byte address.
    for (int i = 0; i < 4096; i++)
      for (int k = 0; k < 8; k++)
        mem[i][k*16 +: 16] = 16'(i * 16 + k * 2);
    mem[4][15:0]  = 16'h1234;
    mem[4][47:32] = 16'h5678;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_address = '0;
    bus.mem_wdata = '0; bus.mem_byte_enable = '0;
    rst_n = 1'b0;
    #2;
    chk("rst_mem_resp", 128'(bus.mem_resp), 128'(0));
    chk("rst_pmem_read", 128'(bus.pmem_read), 128'(0));
    chk("rst_pmem_write", 128'(bus.pmem_write), 128'(0));
    chk("rst_pmem_addr", 128'(bus.pmem_address), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Cold read miss, then hits on the installed line.
    pm_push(1'b0, 16'h0040, '0);
    cpu_req(1, 0, 16'h0040, 16'h0000, 2'b00, 1, 16'h1234, 3);
    cpu_req(0, 1, 16'h0042, 16'hBEEF, 2'b11, 0, 16'h0000, 0);
    cpu_req(1, 0, 16'h0042, 16'h0000, 2'b00, 1, 16'hBEEF, 0);
    cpu_req(0, 1, 16'h0044, 16'hAA00, 2'b10, 0, 16'h0000, 0);
    cpu_req(1, 0, 16'h0044, 16'h0000, 2'b00, 1, 16'hAA78, 0);
    cpu_req(0, 1, 16'h004E, 16'h00CD, 2'b01, 0, 16'h0000, 0);
    cpu_req(1, 0, 16'h004E, 16'h0000, 2'b00, 1, 16'h00CD, 0);
    // Read and write together behave as a store.
    cpu_req(1, 1, 16'h0040, 16'h7777, 2'b11, 0, 16'h0000, 0);
    cpu_req(1, 0, 16'h0040, 16'h0000, 2'b00, 1, 16'h7777, 0);

    // Conflict miss on a dirty line: writeback, then fill.
    pm_push(1'b1, 16'h0040, {16'h00CD, 16'h004C, 16'h004A, 16'h0048,
                             16'h0046, 16'hAA78, 16'hBEEF, 16'h7777});
    pm_push(1'b0, 16'h0440, '0);
    cpu_req(1, 0, 16'h0440, 16'h0000, 2'b00, 1, 16'h0440, 6);
    pm_push(1'b0, 16'h0040, '0);
    cpu_req(1, 0, 16'h0040, 16'h0000, 2'b00, 1, 16'h7777, 3);

    // Request dropped mid-fill: line installed, no response.
    pm_push(1'b0, 16'h00A0, '0);
    bus.mem_read = 1'b1; bus.mem_address = 16'h00A0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (bus.pmem_read) got = 1'b1;
    end
    chk("drop_fill_seen", 128'(got), 128'(1));
    bus.mem_read = 1'b0;
    $display("REQ dropped addr=00a0 during fill");
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    cpu_req(1, 0, 16'h00A2, 16'h0000, 2'b00, 1, 16'h00A2, 0);

    // Store with no bytes enabled must leave the line clean.
    cpu_req(0, 1, 16'h00A4, 16'h9999, 2'b00, 0, 16'h0000, 0);
    cpu_req(1, 0, 16'h00A4, 16'h0000, 2'b00, 1, 16'h00A4, 0);
    pm_push(1'b0, 16'h01A0, '0);
    cpu_req(1, 0, 16'h01A0, 16'h0000, 2'b00, 1, 16'h01A0, 3);

    // Reset during writeback.
    cpu_req(0, 1, 16'h0040, 16'h1111, 2'b11, 0, 16'h0000, 0);
    pm_push(1'b1, 16'h0040, {16'h00CD, 16'h004C, 16'h004A, 16'h0048,
                             16'h0046, 16'hAA78, 16'hBEEF, 16'h1111});
    bus.mem_read = 1'b1; bus.mem_address = 16'h0440;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (bus.pmem_write) got = 1'b1;
    end
    chk("wb_seen", 128'(got), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    $display("REQ async reset during writeback");
    chk("rst_wb_pmem_write", 128'(bus.pmem_write), 128'(0));
    chk("rst_wb_pmem_read", 128'(bus.pmem_read), 128'(0));
    bus.mem_read = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    pm_push(1'b0, 16'h0040, '0);
    cpu_req(1, 0, 16'h0040, 16'h0000, 2'b00, 1, 16'h7777, 3);
    pm_push(1'b0, 16'h00A0, '0);
    cpu_req(1, 0, 16'h00A2, 16'h0000, 2'b00, 1, 16'h00A2, 3);

    repeat (5) @(negedge clk);
    chk("resp_q_empty", 128'(resp_q.size()), 128'(0));
    chk("pmem_q_empty", 128'(pm_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
